// File: rtl/game_pkg.sv
// Shared game definitions: difficulty and mole-state encodings, default
// timing constants and the LFSR step function used by the mole picker.
package game_pkg;

   typedef enum logic [1:0] {
      DIFF_EASY     = 2'd0,
      DIFF_MED      = 2'd1,
      DIFF_HARD     = 2'd2,
      DIFF_HARD_ALT = 2'd3
   } difficulty_e;

   typedef enum logic [1:0] {
      MOLE_IDLE = 2'd0,
      MOLE_GAP  = 2'd1,
      MOLE_UP   = 2'd2
   } mole_state_e;

   localparam int unsigned DEF_UP_T_EASY = 1500;
   localparam int unsigned DEF_UP_T_MED  = 1000;
   localparam int unsigned DEF_UP_T_HARD = 500;
   localparam int unsigned DEF_GAP_T     = 300;
   localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

   // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/mole_controller_if.sv
// Game-control handshake between the game FSM (master) and the mole
// controller (slave): enable/difficulty out, result pulses back.
interface mole_controller_if;
   logic       enable_mole_ctrl;
   logic [1:0] difficulty_level;
   logic       hit_pulse;
   logic       timeout_pulse;
   logic       miss_pulse;

   modport master (
      output enable_mole_ctrl, difficulty_level,
      input  hit_pulse, timeout_pulse, miss_pulse
   );

   modport slave (
      input  enable_mole_ctrl, difficulty_level,
      output hit_pulse, timeout_pulse, miss_pulse
   );
endinterface

// File: rtl/mole_controller_lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every clock, reloads SEED on reset.
module lfsr16
   import game_pkg::*;
#(
   parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] state
);

   logic [15:0] state_d, state_q;

   // next LFSR value
   always_comb state_d = lfsr_next(state_q);

   // state register with synchronous seed load
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= SEED;
      else        state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/mole_controller.sv
// Whack-a-mole responder: pops one mole at a time at an LFSR-chosen hole,
// times it by difficulty and reports hit / timeout (and miss) pulses.
// Optional build macro MOLE_MISS_PENALTY_EN: a wrong-hole whack ends the mole
// with miss_pulse; without it miss_pulse is tied low and wrong holes are ignored.
module mole_controller
   import game_pkg::*;
#(
   parameter int unsigned N_MOLES   = 8,
   parameter int unsigned UP_T_EASY = DEF_UP_T_EASY,
   parameter int unsigned UP_T_MED  = DEF_UP_T_MED,
   parameter int unsigned UP_T_HARD = DEF_UP_T_HARD,
   parameter int unsigned GAP_T     = DEF_GAP_T,
   parameter logic [15:0] LFSR_SEED = DEF_LFSR_SEED
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic [N_MOLES-1:0] btn_whack,
   output logic [N_MOLES-1:0] mole_leds,
   output logic               mole_active,
   mole_controller_if.slave   ctl
);

   localparam int unsigned POS_W  = $clog2(N_MOLES);
   localparam int unsigned T_MAX1 = (UP_T_EASY > UP_T_MED) ? UP_T_EASY : UP_T_MED;
   localparam int unsigned T_MAX2 = (UP_T_HARD > GAP_T) ? UP_T_HARD : GAP_T;
   localparam int unsigned T_MAX  = (T_MAX1 > T_MAX2) ? T_MAX1 : T_MAX2;
   localparam int unsigned CNT_W  = $clog2(T_MAX) + 1;
   localparam logic [N_MOLES-1:0] ONE_HOT = {{(N_MOLES-1){1'b0}}, 1'b1};

   mole_state_e        state_d, state_q;
   logic [CNT_W-1:0]   cnt_d, cnt_q, cnt_inc;
   logic [CNT_W-1:0]   up_t_d, up_t_q, up_t_sel;
   logic [POS_W-1:0]   pos_d, pos_q, last_pos_d, last_pos_q, cand_raw, cand;
   logic [N_MOLES-1:0] btn_prev_d, btn_prev_q, whack_edge;
   logic [N_MOLES-1:0] leds_d, leds_q;
   logic               active_d, active_q;
   logic               hit_d, hit_q, timeout_d, timeout_q;
   logic [15:0]        lfsr_state;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .state (lfsr_state)
   );

   // candidate hole, bumped by one to avoid repeating the previous hole;
   // POS_W-bit wrap gives mod N_MOLES because N_MOLES is a power of two
   always_comb begin
      cand_raw   = lfsr_state[POS_W-1:0];
      cand       = (cand_raw == last_pos_q) ? cand_raw + 1'b1 : cand_raw;
      whack_edge = btn_whack & ~btn_prev_q;
      cnt_inc    = cnt_q + 1'b1;
      case (difficulty_e'(ctl.difficulty_level))
         DIFF_EASY: up_t_sel = CNT_W'(UP_T_EASY);
         DIFF_MED:  up_t_sel = CNT_W'(UP_T_MED);
         default:   up_t_sel = CNT_W'(UP_T_HARD);
      endcase
   end

`ifdef MOLE_MISS_PENALTY_EN
   logic miss_d, miss_q, wrong_edge;
   assign wrong_edge = |(whack_edge & ~(ONE_HOT << pos_q));
`endif

   // next-state, counter and registered-output decode
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      up_t_d     = up_t_q;
      pos_d      = pos_q;
      last_pos_d = last_pos_q;
      btn_prev_d = btn_whack;
      leds_d     = leds_q;
      active_d   = active_q;
      hit_d      = 1'b0;
      timeout_d  = 1'b0;
`ifdef MOLE_MISS_PENALTY_EN
      miss_d     = 1'b0;
`endif
      if (!ctl.enable_mole_ctrl) begin
         // abort: drop the mole silently
         state_d  = MOLE_IDLE;
         cnt_d    = '0;
         leds_d   = '0;
         active_d = 1'b0;
      end else begin
         case (state_q)
            MOLE_IDLE: begin
               state_d  = MOLE_GAP;
               cnt_d    = '0;
               leds_d   = '0;
               active_d = 1'b0;
            end
            MOLE_GAP: begin
               if (tick) begin
                  if (cnt_inc == CNT_W'(GAP_T)) begin
                     state_d    = MOLE_UP;
                     cnt_d      = '0;
                     pos_d      = cand;
                     last_pos_d = cand;
                     up_t_d     = up_t_sel;
                     leds_d     = ONE_HOT << cand;
                     active_d   = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
            end
            MOLE_UP: begin
`ifdef MOLE_MISS_PENALTY_EN
               if (wrong_edge) begin
                  miss_d = 1'b1;
               end else
`endif
               if (whack_edge[pos_q]) begin
                  hit_d = 1'b1;
               end else if (tick) begin
                  if (cnt_inc == up_t_q) timeout_d = 1'b1;
                  else                   cnt_d     = cnt_inc;
               end
`ifdef MOLE_MISS_PENALTY_EN
               if (hit_d || timeout_d || miss_d) begin
`else
               if (hit_d || timeout_d) begin
`endif
                  state_d  = MOLE_GAP;
                  cnt_d    = '0;
                  leds_d   = '0;
                  active_d = 1'b0;
               end
            end
            default: state_d = MOLE_IDLE;
         endcase
      end
   end

   // state and output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= MOLE_IDLE;
         cnt_q      <= '0;
         up_t_q     <= '0;
         pos_q      <= '0;
         last_pos_q <= '0;
         btn_prev_q <= '0;
         leds_q     <= '0;
         active_q   <= 1'b0;
         hit_q      <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         up_t_q     <= up_t_d;
         pos_q      <= pos_d;
         last_pos_q <= last_pos_d;
         btn_prev_q <= btn_prev_d;
         leds_q     <= leds_d;
         active_q   <= active_d;
         hit_q      <= hit_d;
         timeout_q  <= timeout_d;
      end
   end

`ifdef MOLE_MISS_PENALTY_EN
   // miss pulse register
   always_ff @(posedge clk) begin
      if (!rst_n) miss_q <= 1'b0;
      else        miss_q <= miss_d;
   end
   assign ctl.miss_pulse = miss_q;
`else
   assign ctl.miss_pulse = 1'b0;
`endif

   assign mole_leds         = leds_q;
   assign mole_active       = active_q;
   assign ctl.hit_pulse     = hit_q;
   assign ctl.timeout_pulse = timeout_q;

endmodule

// File: tb/tb_mole_controller.sv
// Testbench for mole_controller: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural game model.
module tb_mole_controller;

   localparam int N   = 8;
   localparam int GAP = 3;
   localparam int UE  = 10;
   localparam int UM  = 6;
   localparam int UH  = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic [7:0] btn;
   logic [7:0] mole_leds;
   logic       mole_active;

   mole_controller_if gif ();

   mole_controller #(
      .N_MOLES   (N),
      .UP_T_EASY (UE),
      .UP_T_MED  (UM),
      .UP_T_HARD (UH),
      .GAP_T     (GAP),
      .LFSR_SEED (16'hACE1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .btn_whack   (btn),
      .mole_leds   (mole_leds),
      .mole_active (mole_active),
      .ctl         (gif)
   );

   initial forever #5 clk = ~clk;

   int n_pass = 0, n_tot = 0, cyc_n = 0;
   int hit_seen = 0, to_seen = 0, miss_seen = 0;
   logic last_tick = 1'b0;

   // behavioural model: phase 0 idle, 1 gap, 2 mole up
   logic [15:0] m_lfsr;
   logic [7:0]  m_prev;
   int          m_last, m_pos, m_phase, m_count, m_uptime;
   logic [7:0]  e_leds;
   logic        e_active, e_hit, e_to, e_miss;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_step();
      logic [7:0] edges;
      int         cand;
      bit         ended;
      if (!rst_n) begin
         m_lfsr = 16'hACE1; m_prev = '0; m_last = 0; m_pos = 0;
         m_phase = 0; m_count = 0; m_uptime = UE;
         e_leds = '0; e_active = 0; e_hit = 0; e_to = 0; e_miss = 0;
         return;
      end
      edges  = btn & ~m_prev;
      m_prev = btn;
      cand   = m_lfsr % N;
      if (cand == m_last) cand = (cand + 1) % N;
      e_hit = 0; e_to = 0; e_miss = 0;
      if (!gif.enable_mole_ctrl) begin
         m_phase = 0; e_leds = '0; e_active = 0;
      end else if (m_phase == 0) begin
         m_phase = 1; m_count = 0;
      end else if (m_phase == 1) begin
         if (tick) begin
            m_count++;
            if (m_count == GAP) begin
               m_phase  = 2; m_count = 0; m_pos = cand; m_last = cand;
               m_uptime = (gif.difficulty_level == 0) ? UE :
                          (gif.difficulty_level == 1) ? UM : UH;
               e_leds   = 8'd1 << cand; e_active = 1;
            end
         end
      end else begin
         ended = 0;
`ifdef MOLE_MISS_PENALTY_EN
         if ((edges & ~(8'd1 << m_pos)) != 0) begin e_miss = 1; ended = 1; end else
`endif
         if (edges[m_pos]) begin
            e_hit = 1; ended = 1;
         end else if (tick) begin
            m_count++;
            if (m_count == m_uptime) begin e_to = 1; ended = 1; end
         end
         if (ended) begin m_phase = 1; m_count = 0; e_leds = '0; e_active = 0; end
      end
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   endtask

   task automatic cyc();
      @(posedge clk);
      last_tick = tick;
      model_step();
      cyc_n++;
      #1;
      chk("mole_leds", mole_leds, e_leds);
      chk("mole_active", mole_active, e_active);
      chk("hit_pulse", gif.hit_pulse, e_hit);
      chk("timeout_pulse", gif.timeout_pulse, e_to);
      chk("miss_pulse", gif.miss_pulse, e_miss);
      if (gif.hit_pulse === 1'b1)     hit_seen++;
      if (gif.timeout_pulse === 1'b1) to_seen++;
      if (gif.miss_pulse === 1'b1)    miss_seen++;
      tick = ((cyc_n % 4) == 0);
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic wait_level(input logic v, input string tag);
      int k = 0;
      while (mole_active !== v && k < 300) begin cyc(); k++; end
      chk(tag, (k < 300), 1);
   endtask

   int c0, h0, t0, m0, p0, nt, k;

   initial begin
      rst_n = 1'b0; tick = 1'b0; btn = '0;
      gif.enable_mole_ctrl = 1'b0; gif.difficulty_level = 2'd0;

      // 1: reset, then idle with enable low
      run(3);
      rst_n = 1'b1;
      run(50);
      chk("s1 idle leds", mole_leds, 0);

      // 2: easy mole times out, next mole follows
      gif.enable_mole_ctrl = 1'b1;
      t0 = to_seen;
      wait_level(1'b1, "s2 first rise");
      wait_level(1'b0, "s2 first fall");
      chk("s2 timeout count", to_seen - t0, 1);
      wait_level(1'b1, "s2 second rise");

      // 3: hit mid-mole, then hold the button through the next mole
      run(5);
      h0 = hit_seen; t0 = to_seen;
      btn[m_pos] = 1'b1;
      run(1);
      chk("s3 hit now", gif.hit_pulse, 1);
      chk("s3 leds off", mole_leds, 0);
      run(1);
      wait_level(1'b1, "s3 next rise");
      wait_level(1'b0, "s3 next fall");
      chk("s3 single hit", hit_seen - h0, 1);
      chk("s3 one timeout", to_seen - t0, 1);
      btn = '0;

      // 4: difficulty change mid-mole affects only the next mole
      wait_level(1'b1, "s4 rise a");
      c0 = cyc_n;
      run(2);
      gif.difficulty_level = 2'd2;
      wait_level(1'b0, "s4 fall a");
      chk("s4 easy length", cyc_n - c0, UE * 4);
      wait_level(1'b1, "s4 rise b");
      c0 = cyc_n;
      wait_level(1'b0, "s4 fall b");
      chk("s4 hard length", cyc_n - c0, UH * 4);
      gif.difficulty_level = 2'd3;
      wait_level(1'b1, "s4 rise c");
      c0 = cyc_n;
      wait_level(1'b0, "s4 fall c");
      chk("s4 diff3 length", cyc_n - c0, UH * 4);

      // 5: hit edge on the final tick, then abort and re-enable
      wait_level(1'b1, "s5 rise");
      k = 0;
      while (!(m_phase == 2 && m_count == m_uptime - 1 && tick == 1'b1) && k < 100) begin
         cyc(); k++;
      end
      chk("s5 reach final tick", (k < 100), 1);
      btn[m_pos] = 1'b1;
      run(1);
      chk("s5 hit wins", gif.hit_pulse, 1);
      chk("s5 no timeout", gif.timeout_pulse, 0);
      btn = '0;
      wait_level(1'b1, "s5 abort rise");
      run(2);
      p0 = hit_seen + to_seen + miss_seen;
      gif.enable_mole_ctrl = 1'b0;
      run(1);
      chk("s5 abort leds", mole_leds, 0);
      run(6);
      chk("s5 abort no pulse", hit_seen + to_seen + miss_seen - p0, 0);
      gif.enable_mole_ctrl = 1'b1;
      run(1);
      nt = 0; k = 0;
      while (mole_active !== 1'b1 && k < 100) begin
         cyc(); k++;
         if (last_tick) nt++;
      end
      chk("s5 full gap ticks", nt, GAP);

      // 6: wrong-hole edge, then wrong and right together
      run(1);
      m0 = miss_seen; t0 = to_seen;
      btn[(m_pos + 1) % N] = 1'b1;
      run(1);
`ifdef MOLE_MISS_PENALTY_EN
      chk("s6 miss", gif.miss_pulse, 1);
      chk("s6 mole ended", mole_active, 0);
`else
      chk("s6 no miss", gif.miss_pulse, 0);
      chk("s6 mole stays", mole_active, 1);
      wait_level(1'b0, "s6 fall");
      chk("s6 timed out", to_seen - t0, 1);
`endif
      btn = '0;
      wait_level(1'b1, "s6 rise b");
      run(1);
      btn = (8'd1 << m_pos) | (8'd1 << ((m_pos + 1) % N));
      run(1);
`ifdef MOLE_MISS_PENALTY_EN
      chk("s6 both miss", gif.miss_pulse, 1);
      chk("s6 both no hit", gif.hit_pulse, 0);
`else
      chk("s6 both hit", gif.hit_pulse, 1);
      chk("s6 both no miss", gif.miss_pulse, 0);
`endif
      chk("s6 miss total", miss_seen - m0,
`ifdef MOLE_MISS_PENALTY_EN
          2);
`else
          0);
`endif
      btn = '0;

      // random play
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) == 0) btn = btn ^ (8'd1 << $urandom_range(0, 7));
         if (m_phase == 2 && $urandom_range(0, 19) == 0) btn[m_pos] = 1'b1;
         if ($urandom_range(0, 149) == 0) gif.difficulty_level = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 399) == 0) gif.enable_mole_ctrl = ~gif.enable_mole_ctrl;
         if (i == 2000) rst_n = 1'b0;
         if (i == 2002) rst_n = 1'b1;
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/mole_controller.md
Name: mole_controller

Overview:
- Responder side of the game-control handshake: consumes enable_mole_ctrl and difficulty_level from the game FSM, and returns hit_pulse, timeout_pulse and miss_pulse.
- Pops one mole at a time on a one-hot LED bank.
- Mole position comes from a free-running LFSR; up-time is set by difficulty.
- Whacks arrive as debounced level buttons; all edge detection is internal.

Parameters:
N_MOLES, 8, mole count; power of two, 2..16
UP_T_EASY, 1500, mole up-time in ticks, difficulty 0
UP_T_MED, 1000, mole up-time in ticks, difficulty 1
UP_T_HARD, 500, mole up-time in ticks, difficulty 2 or 3
GAP_T, 300, ticks between moles
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
tick  in  1  one-cycle timebase pulse (1 kHz in system)
enable_mole_ctrl  in  1  level; high while game is PLAYING
difficulty_level  in  2  0 easy, 1 med, 2/3 hard
btn_whack  in  N_MOLES  debounced whack buttons, level
mole_leds  out  N_MOLES  one-hot active mole, else 0
mole_active  out  1  high while a mole is up
hit_pulse  out  1  one cycle per correct whack
timeout_pulse  out  1  one cycle per mole expiring unhit
miss_pulse  out  1  one cycle per wrong whack (feature only)

Behaviour:
- Reset (clk edge with rst_n=0):
  - all outputs 0; state IDLE; tick counter 0; btn_prev 0; lfsr=LFSR_SEED; last_pos 0.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clk in every state, including IDLE.
  - cand = lfsr[log2(N_MOLES)-1:0]; if cand==last_pos, use cand+1 mod N_MOLES (no back-to-back repeat).
- Edge detect: whack_edge = btn_whack & ~btn_prev; btn_prev registered every clk.
- States:
  - IDLE: outputs 0. enable_mole_ctrl=1 -> GAP, counter cleared.
  - GAP: LEDs off. Counter increments on tick. On the tick that makes count==GAP_T:
    - -> UP, pos=cand, last_pos=cand;
    - up_t latched from difficulty_level (sampled once per mole; a mid-mole change affects the next mole only);
    - counter cleared.
  - UP: mole_leds=1<<pos and mole_active=1, registered, asserted first cycle in UP.
    - whack_edge[pos]=1 -> hit_pulse=1 next cycle, LEDs off that same cycle, -> GAP.
    - else, on the tick that makes count==up_t: timeout_pulse=1 next cycle, -> GAP.
- Same-cycle hit edge and final tick: hit wins, no timeout.
- Edges on non-active holes in UP: ignored (no feature). Edges in IDLE/GAP: ignored always.
- Button held from GAP into UP: no edge, so no hit.
- enable_mole_ctrl low in any state: next cycle IDLE, LEDs 0, no pulse issued for the aborted mole; a pulse already registered completes its single cycle.
- Re-enable after abort: starts with a full GAP.
- Pulses are never longer than one cycle; at most one of hit/timeout/miss per mole.
- Counter width is clog2 of the largest T parameter plus 1; no wrap within legal params.

Optional Feature:
MOLE_MISS_PENALTY_EN
- Defined: in UP, any whack_edge on a hole other than pos -> miss_pulse next cycle, mole ends, -> GAP.
  - Wrong and correct edges in the same cycle: miss wins (anti-mash).
  - Miss and final tick in the same cycle: miss wins.
- Undefined: miss_pulse tied 0; wrong-hole edges ignored.

Decomposition:
- Shared package game_pkg:
  - difficulty encodings DIFF_EASY/MED/HARD;
  - mole state encodings MOLE_IDLE/GAP/UP;
  - default timing constants.
- One sub-module lfsr16 (clk, rst_n, seed param, 16-bit state out); the rest stays flat.

Test Plan:
- Sim params: N_MOLES=8, GAP_T=3, UP_T_EASY=10, UP_T_MED=6, UP_T_HARD=3; tick every 4 clks.
1. Reset held 3 clks, then release with enable=0 for 50 clks -> all outputs 0, state IDLE.
2. enable=1, difficulty=0, no buttons -> LEDs rise after 3rd tick, one-hot; fall after 10th tick; timeout_pulse exactly 1 clk; next mole at a different position.
3. Mole at pos p, btn_whack[p] rises mid-UP -> hit_pulse 1 clk later, LEDs 0 same cycle, no timeout_pulse; holding the button through the next mole produces no second hit.
4. difficulty=2 set mid-mole -> current mole still lasts 10 ticks; the next lasts 3. difficulty=3 -> 3 ticks.
5. Hit edge coincident with the final tick -> hit_pulse only. enable drops during UP -> LEDs 0 next clk, no pulses; re-enable gives a full 3-tick GAP.
6. MOLE_MISS_PENALTY_EN defined: wrong-hole edge -> miss_pulse 1 clk, mole ends; wrong+right edges same clk -> miss_pulse only. Undefined: miss_pulse stays 0 and the mole times out.
